// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-requester memory bus arbiter.
package mem_arb_pkg;

    localparam int unsigned NREQ   = 3;
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 32;

    // Index of the requester that owns the bus.
    typedef logic [1:0] grant_idx_t;

    // After reset, requester 0 is first in line.
    localparam grant_idx_t LastGrantRst = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-unit signals of the arbiter, bundled with the arbiter-side
// (master) and environment-side (slave) views.
interface mem_bus_arbiter_if;
    import mem_arb_pkg::*;

    logic              r0_req, r1_req, r2_req;
    logic [ADDR_W-1:0] r0_addr, r1_addr, r2_addr;
    logic [DATA_W-1:0] r0_data, r1_data, r2_data;
    logic              r0_we, r1_we, r2_we;
    logic              r0_ack, r1_ack, r2_ack;
    logic [DATA_W-1:0] rd_q;
    logic              err;
    grant_idx_t        grant;
    logic              active;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_start;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_q;
    logic              mem_init_done;

    modport master (
        input  r0_req, r1_req, r2_req, r0_addr, r1_addr, r2_addr,
        input  r0_data, r1_data, r2_data, r0_we, r1_we, r2_we,
        output r0_ack, r1_ack, r2_ack, rd_q, err, grant, active,
        output mem_addr, mem_data, mem_we, mem_start,
        input  mem_busy, mem_q, mem_init_done
    );

    modport slave (
        output r0_req, r1_req, r2_req, r0_addr, r1_addr, r2_addr,
        output r0_data, r1_data, r2_data, r0_we, r1_we, r2_we,
        input  r0_ack, r1_ack, r2_ack, rd_q, err, grant, active,
        input  mem_addr, mem_data, mem_we, mem_start,
        output mem_busy, mem_q, mem_init_done
    );

endinterface

// File: rtl/rr_pick3.sv
// Round-robin pick among three requests, searching from the one after the last grant.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  grant_idx_t last_i,
    output logic [2:0] onehot_o,
    output grant_idx_t idx_o,
    output logic       any_o
);

    grant_idx_t cand;

    // First asserted request at (last+1), (last+2), (last+3) mod 3.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= 3; k++) begin
            cand = grant_idx_t'((int'(last_i) + k) % 3);
            if (!any_o && req_i[cand]) begin
                any_o           = 1'b1;
                idx_o           = cand;
                onehot_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates three single-access requesters onto one memory unit, one transaction at a
// time, with a per-transaction timeout that answers with err=1 and zero read data.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned NREQ           = mem_arb_pkg::NREQ
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bus
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    grant_idx_t        grant_q, grant_d;
    grant_idx_t        last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   req_vec;
    logic [2:0]        pick_onehot;
    grant_idx_t        pick_idx;
    logic              pick_any;
    logic              timeout;

    assign req_vec = {bus.r2_req, bus.r1_req, bus.r0_req};
    assign timeout = (cnt_q == CntLast);

    rr_pick3 u_pick (
        .req_i    (req_vec),
        .last_i   (last_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            grant_q   <= '0;
            last_q    <= LastGrantRst;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    // Next-state: grant in IDLE, track the memory unit, timeout takes priority.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        last_d    = last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = we_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_init_done && pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = StIssue;
                    unique case (pick_onehot)
                        3'b001: begin
                            addr_d = bus.r0_addr;
                            data_d = bus.r0_data;
                            we_d   = bus.r0_we;
                        end
                        3'b010: begin
                            addr_d = bus.r1_addr;
                            data_d = bus.r1_data;
                            we_d   = bus.r1_we;
                        end
                        3'b100: begin
                            addr_d = bus.r2_addr;
                            data_d = bus.r2_data;
                            we_d   = bus.r2_we;
                        end
                        default: ;
                    endcase
                end
            end
            StIssue, StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (timeout) begin
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    state_d   = StResp;
                end else if (state_q == StIssue && bus.mem_busy) begin
                    state_d = StWait;
                end else if (state_q == StWait && !bus.mem_busy) begin
                    rd_data_d = bus.mem_q;
                    err_d     = 1'b0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                last_d  = grant_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Start is dropped in the very cycle busy falls so the unit is never re-triggered.
    assign bus.mem_start = (state_q == StIssue) || (state_q == StWait && bus.mem_busy);

    assign bus.r0_ack   = (state_q == StResp) && (grant_q == 2'd0);
    assign bus.r1_ack   = (state_q == StResp) && (grant_q == 2'd1);
    assign bus.r2_ack   = (state_q == StResp) && (grant_q == 2'd2);
    assign bus.err      = (state_q == StResp) && err_q;
    assign bus.rd_q     = rd_data_q;
    assign bus.grant    = grant_q;
    assign bus.active   = (state_q != StIdle);
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.mem_we   = we_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed bench for mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .NREQ           (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Requester drive
    logic [2:0]  req;
    logic [26:0] addr  [3];
    logic [31:0] wdata [3];
    logic [2:0]  we;
    logic        init_done;
    logic [2:0]  ack_v;

    assign bus.r0_req  = req[0];
    assign bus.r1_req  = req[1];
    assign bus.r2_req  = req[2];
    assign bus.r0_addr = addr[0];
    assign bus.r1_addr = addr[1];
    assign bus.r2_addr = addr[2];
    assign bus.r0_data = wdata[0];
    assign bus.r1_data = wdata[1];
    assign bus.r2_data = wdata[2];
    assign bus.r0_we   = we[0];
    assign bus.r1_we   = we[1];
    assign bus.r2_we   = we[2];
    assign bus.mem_init_done = init_done;
    assign ack_v = {bus.r2_ack, bus.r1_ack, bus.r0_ack};

    // Memory unit: starts on mem_start when free, busy for a chosen latency.
    int          busy_cnt;
    logic [31:0] mem_q_r;
    logic        stuck;
    int          fixed_lat;

    function automatic logic [31:0] rd_fn(input logic [26:0] a);
        if (a == 27'h10) return 32'hDEADBEEF;
        return {5'b0, a} ^ 32'hA5A5_0000;
    endfunction

    assign bus.mem_busy = (busy_cnt != 0) || stuck;
    assign bus.mem_q    = mem_q_r;

    always @(posedge clk) begin
        if (!reset) begin
            busy_cnt <= 0;
            mem_q_r  <= '0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (bus.mem_start && !stuck) begin
            busy_cnt <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 12));
            mem_q_r  <= rd_fn(bus.mem_addr);
        end
    end

    // Counters and comparison helper
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    endtask

    // Transaction-level reference model
    bit          m_fly, m_resp, m_seen, m_err;
    int          m_owner, m_last, m_age;
    logic [31:0] m_rd, m_data;
    logic [26:0] m_addr;
    logic        m_we;

    function automatic int rr_next(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (r[(last + k) % 3]) return (last + k) % 3;
        end
        return 0;
    endfunction

    initial begin
        m_fly = 0; m_resp = 0; m_seen = 0; m_err = 0;
        m_owner = 0; m_last = 2; m_age = 0;
        m_rd = '0; m_data = '0; m_addr = '0; m_we = 1'b0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            m_fly = 0; m_resp = 0; m_seen = 0; m_err = 0;
            m_owner = 0; m_last = 2; m_age = 0;
            m_rd = '0; m_data = '0; m_addr = '0; m_we = 1'b0;
        end else if (m_resp) begin
            m_resp = 0;
            m_last = m_owner;
        end else if (m_fly) begin
            m_age++;
            if (m_age == TO) begin
                m_fly = 0; m_resp = 1; m_rd = '0; m_err = 1;
            end else if (m_seen && !bus.mem_busy) begin
                m_fly = 0; m_resp = 1; m_rd = bus.mem_q; m_err = 0;
            end else if (bus.mem_busy) begin
                m_seen = 1;
            end
        end else if (init_done && req != 3'b000) begin
            m_owner = rr_next(req, m_last);
            m_addr  = addr[m_owner];
            m_data  = wdata[m_owner];
            m_we    = we[m_owner];
            m_fly   = 1; m_age = 0; m_seen = 0;
        end
    end

    // Per-cycle compare of every output against the model
    bit chk_en = 0;

    always @(negedge clk) begin
        logic [99:0] act, exp;
        logic        e_active;
        if (chk_en) begin
            e_active = m_fly || m_resp;
            exp = {(m_resp ? (3'b001 << m_owner) : 3'b000), m_resp && m_err, e_active,
                   (e_active ? 2'(m_owner) : 2'b00), m_fly && (!m_seen || bus.mem_busy),
                   m_we, m_addr, m_data, m_rd};
            act = {ack_v, bus.err, bus.active, (bus.active ? bus.grant : 2'b00),
                   bus.mem_start, bus.mem_we, bus.mem_addr, bus.mem_data, bus.rd_q};
            check("cycle_outputs", 128'(act), 128'(exp));
        end
    end

    // Wait for requester idx's ack; drop its request then and confirm the pulse is one cycle.
    task automatic wait_ack(input int idx, input int budget, output int lat, output logic e,
                            output logic [31:0] rd, output logic prev_start);
        logic ps;
        bit   got;
        lat = 0; e = 1'b0; rd = '0; prev_start = 1'b0; got = 0;
        for (int c = 0; c < budget; c++) begin
            ps = bus.mem_start;
            @(negedge clk);
            lat++;
            if (ack_v[idx]) begin
                e = bus.err; rd = bus.rd_q; prev_start = ps;
                req[idx] = 1'b0;
                got = 1;
                break;
            end
        end
        check($sformatf("ack%0d_seen", idx), 128'(got), 128'(1));
        if (got) begin
            @(negedge clk);
            check($sformatf("ack%0d_one_cycle", idx), 128'(ack_v[idx]), 128'(0));
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        req  = 3'b000;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!bus.active) begin done = 1; break; end
        end
        check("drain_idle", 128'(done), 128'(1));
    endtask

    int          lat, s_cnt, a_cnt, n_ack;
    logic        e, ps;
    logic [31:0] rd;
    int          order[$];
    int          exp_order[6];
    int          gap[3];
    logic [2:0]  reraise;
    bit          r1_on, ok;

    initial begin
        reset = 1'b0; init_done = 1'b0; req = 3'b000; we = 3'b000;
        stuck = 1'b0; fixed_lat = 0;
        for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; end
        exp_order = '{0, 1, 2, 0, 1, 2};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        check("reset_active", 128'(bus.active), 128'(0));
        check("reset_acks", 128'(ack_v), 128'(0));
        check("reset_rd_q", 128'(bus.rd_q), 128'(0));
        check("reset_start", 128'(bus.mem_start), 128'(0));
        reset = 1'b1;

        // No grant until the memory unit finishes initialising
        addr[2] = 27'h155; wdata[2] = 32'h1234; we[2] = 1'b0; req[2] = 1'b1;
        fixed_lat = 4;
        s_cnt = 0; a_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_start) s_cnt++;
            if (bus.active) a_cnt++;
        end
        check("noinit_start", 128'(s_cnt), 128'(0));
        check("noinit_active", 128'(a_cnt), 128'(0));
        init_done = 1'b1;
        @(negedge clk);
        check("init_grant", 128'({bus.active, bus.grant}), 128'({1'b1, 2'd2}));
        wait_ack(2, 60, lat, e, rd, ps);
        check("init_rd_q", 128'(rd), 128'(rd_fn(27'h155)));

        // Single read, busy five cycles
        addr[1] = 27'h10; we[1] = 1'b0; req[1] = 1'b1; fixed_lat = 5;
        wait_ack(1, 60, lat, e, rd, ps);
        check("read_latency", 128'(lat), 128'(8));
        check("read_rd_q", 128'(rd), 128'(32'hDEADBEEF));
        check("read_err", 128'(e), 128'(0));
        check("read_start_low", 128'(ps), 128'(0));

        // Three continuous requesters from reset
        reset = 1'b0;
        fixed_lat = 0;
        for (int i = 0; i < 3; i++) begin addr[i] = 27'($urandom); we[i] = 1'b0; end
        req = 3'b111; reraise = 3'b000;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 300 && order.size() < 6; c++) begin
            @(negedge clk);
            req = req | reraise;
            reraise = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (ack_v[i]) begin
                    order.push_back(i);
                    req[i] = 1'b0;
                    reraise[i] = 1'b1;
                    addr[i] = 27'($urandom);
                end
            end
        end
        req = 3'b000;
        check("rr_count", 128'(order.size()), 128'(6));
        for (int i = 0; i < 6 && i < order.size(); i++)
            check($sformatf("rr_order%0d", i), 128'(order[i]), 128'(exp_order[i]));
        drain();

        // Non-granted requester wiggling its address must not disturb the bus
        addr[0] = 27'hC0262E; wdata[0] = 32'h41; we[0] = 1'b1; req[0] = 1'b1;
        fixed_lat = 6; r1_on = 0; ok = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.active && bus.grant == 2'd0) begin
                check("hold_bus", 128'({bus.mem_we, bus.mem_addr, bus.mem_data}),
                      128'({1'b1, 27'hC0262E, 32'h41}));
            end
            if (ack_v[0]) begin req[0] = 1'b0; ok = 1; break; end
            if (bus.active) begin
                if (!r1_on) begin req[1] = 1'b1; we[1] = 1'b0; r1_on = 1; end
                addr[1] = 27'($urandom);
                wdata[1] = $urandom;
            end
        end
        check("hold_ack0", 128'(ok), 128'(1));
        wait_ack(1, 60, lat, e, rd, ps);
        check("hold_after_r1_rd", 128'(rd), 128'(rd_fn(addr[1])));

        // Stuck memory unit times out
        stuck = 1'b1; addr[0] = 27'h2AB; we[0] = 1'b0; req[0] = 1'b1;
        wait_ack(0, 60, lat, e, rd, ps);
        check("timeout_latency", 128'(lat), 128'(TO + 1));
        check("timeout_err", 128'(e), 128'(1));
        check("timeout_rd_q", 128'(rd), 128'(0));
        stuck = 1'b0;
        addr[0] = 27'h123; fixed_lat = 3; req[0] = 1'b1;
        wait_ack(0, 60, lat, e, rd, ps);
        check("after_timeout_err", 128'(e), 128'(0));
        check("after_timeout_rd_q", 128'(rd), 128'(rd_fn(27'h123)));

        // Reset while waiting on the memory unit
        addr[1] = 27'h3C; we[1] = 1'b1; wdata[1] = 32'h77; req[1] = 1'b1; fixed_lat = 8;
        a_cnt = 0;
        for (int c = 0; c < 20 && a_cnt < 2; c++) begin
            @(negedge clk);
            if (bus.active && bus.mem_busy) a_cnt++;
        end
        check("reached_wait", 128'(a_cnt), 128'(2));
        reset = 1'b0; req[1] = 1'b0;
        @(negedge clk);
        check("reset_in_wait",
              128'({ack_v, bus.err, bus.active, bus.grant, bus.mem_start, bus.mem_we,
                    bus.mem_addr, bus.mem_data, bus.rd_q}), 128'(0));
        reset = 1'b1;
        n_ack = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack_v != 3'b000) n_ack++;
        end
        check("no_ack_after_reset", 128'(n_ack), 128'(0));

        // Random traffic
        fixed_lat = 0; n_ack = 0;
        for (int i = 0; i < 3; i++) gap[i] = int'($urandom_range(0, 3));
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            init_done = ($urandom_range(0, 15) != 0);
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    if (ack_v[i]) begin
                        req[i] = 1'b0; n_ack++;
                        gap[i] = int'($urandom_range(0, 3));
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    addr[i] = 27'($urandom); wdata[i] = $urandom; we[i] = 1'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        init_done = 1'b1;
        check("random_progress", 128'(n_ack > 100), 128'(1));
        drain();

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
